regfile_scoreboard: RTL and testbench

Parametrised register file with an integrated per-register pending-write scoreboard for the decode stage of the pipelined core. It provides two asynchronous read ports, one writeback port, and write-after-issue hazard tracking. Decode issues an instruction only when `issue_ready` is high. Writeback retires pending writes. An optional writeback-to-read bypass removes the one-cycle write-then-read bubble.

---
 rtl/regfile_scoreboard.sv | 146 ++++++++++++++
 tb/tb_regfile_scoreboard.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: parametrised register file with a per-register
// pending-write scoreboard for the decode stage.
//   - two combinational read ports, one writeback port
//   - issue_ready gates decode on source (RAW) and destination (counter
//     saturation) hazards
//   - optional feature macro: REGFILE_BYPASS_EN
//       defined   : writeback data forwarded to read ports, and a count-1
//                   source retiring this cycle does not block
//       undefined : no forwarding, sources must have a zero count
module regfile_scoreboard #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int IDX_W  = $clog2(NREGS),
    parameter int CNT_W  = 2
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_a_id,
    input  logic [IDX_W-1:0]  rd_b_id,
    output logic [DATA_W-1:0] rd_a_data,
    output logic [DATA_W-1:0] rd_b_data,
    input  logic              issue_valid,
    input  logic [IDX_W-1:0]  issue_rs_id,
    input  logic [IDX_W-1:0]  issue_rt_id,
    input  logic              issue_use_rs,
    input  logic              issue_use_rt,
    input  logic              issue_wr,
    input  logic [IDX_W-1:0]  issue_dst_id,
    output logic              issue_ready,
    input  logic              wb_valid,
    input  logic [IDX_W-1:0]  wb_id,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              busy,
    output logic              wb_orphan
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // Architectural state.
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [CNT_W-1:0]  pend_q [NREGS];
    logic [CNT_W-1:0]  pend_d [NREGS];
    logic              busy_q, busy_d;
    logic              orphan_q, orphan_d;

    // Hazard evaluation signals.
    logic [CNT_W-1:0]  rs_cnt, rt_cnt, dst_cnt, wb_cnt;
    logic              rs_block, rt_block, dst_block;
    logic              fire;
    logic [NREGS-1:0]  inc_vec, dec_vec;

    assign rs_cnt  = pend_q[issue_rs_id];
    assign rt_cnt  = pend_q[issue_rt_id];
    assign dst_cnt = pend_q[issue_dst_id];
    assign wb_cnt  = pend_q[wb_id];

    // Read ports: index 0 is hardwired zero; optional same-cycle forwarding.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the block can leave it unassigned and infer a latch.
        rd_a_data = regs_q[rd_a_id];
        rd_b_data = regs_q[rd_b_id];
        if (BYPASS && wb_valid && wb_id == rd_a_id) rd_a_data = wb_data;
        if (BYPASS && wb_valid && wb_id == rd_b_id) rd_b_data = wb_data;
        if (rd_a_id == '0) rd_a_data = '0;
        if (rd_b_id == '0) rd_b_data = '0;
    end

    // Issue hazards: pending-write sources and saturated destination counters.
    always_comb begin
        rs_block = issue_use_rs && (issue_rs_id != '0) && (rs_cnt != '0);
        rt_block = issue_use_rt && (issue_rt_id != '0) && (rt_cnt != '0);
        // A single outstanding write retiring right now is forwarded instead.
        if (BYPASS && rs_cnt == CNT_ONE && wb_valid && wb_id == issue_rs_id) rs_block = 1'b0;
        if (BYPASS && rt_cnt == CNT_ONE && wb_valid && wb_id == issue_rt_id) rt_block = 1'b0;
        dst_block   = issue_wr && (issue_dst_id != '0) && (dst_cnt == CNT_MAX);
        issue_ready = !flush && !(rs_block || rt_block || dst_block);
        fire        = issue_valid && issue_ready;
    end

    // Pending counter next state: +1 on claimed issue, -1 on retire, flush clears.
    always_comb begin
        busy_d = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            inc_vec[r] = fire && issue_wr && (issue_dst_id == IDX_W'(r));
            dec_vec[r] = wb_valid && (wb_id == IDX_W'(r)) && (pend_q[r] != '0);
            pend_d[r]  = pend_q[r];
            if (flush) begin
                pend_d[r] = '0;
            end else if (inc_vec[r] && !dec_vec[r]) begin
                pend_d[r] = pend_q[r] + CNT_ONE;
            end else if (dec_vec[r] && !inc_vec[r]) begin
                pend_d[r] = pend_q[r] - CNT_ONE;
            end
        end
        // Register 0 is never tracked.
        pend_d[0] = '0;
        for (int r = 0; r < NREGS; r++) begin
            busy_d |= (pend_d[r] != '0);
        end
    end

    // Sticky orphan flag: retire of a register with nothing outstanding.
    always_comb begin
        orphan_d = orphan_q;
        if (wb_valid && (wb_id != '0) && (wb_cnt == '0) && !flush) orphan_d = 1'b1;
    end

    // Data storage: writeback always lands, regardless of the counter value.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            // NOTE: this array is reset on purpose -- reads after reset must
            // return zero, so the storage cannot be left as an unreset RAM.
            for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
        end else if (wb_valid && (wb_id != '0)) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values, independent of block ordering.
            regs_q[wb_id] <= wb_data;
        end
    end

    // Scoreboard counters and status flags.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) pend_q[r] <= '0;
            busy_q   <= 1'b0;
            orphan_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) pend_q[r] <= pend_d[r];
            busy_q   <= busy_d;
            orphan_q <= orphan_d;
        end
    end

    assign busy      = busy_q;
    assign wb_orphan = orphan_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios followed by
// randomized traffic compared against a behavioural reference model.
// Honours REGFILE_BYPASS_EN the same way as the design.
module tb_regfile_scoreboard;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int IW = 5;
    localparam int MAXC = 3;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          sys_clk = 1'b0;
    logic          rst;
    logic [IW-1:0] rd_a_id, rd_b_id;
    logic [DW-1:0] rd_a_data, rd_b_data;
    logic          issue_valid, issue_use_rs, issue_use_rt, issue_wr;
    logic [IW-1:0] issue_rs_id, issue_rt_id, issue_dst_id;
    logic          issue_ready;
    logic          wb_valid;
    logic [IW-1:0] wb_id;
    logic [DW-1:0] wb_data;
    logic          flush;
    logic          busy, wb_orphan;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_scoreboard #(.DATA_W(DW), .NREGS(NR), .CNT_W(2)) dut (
        .sys_clk(sys_clk), .rst(rst),
        .rd_a_id(rd_a_id), .rd_b_id(rd_b_id),
        .rd_a_data(rd_a_data), .rd_b_data(rd_b_data),
        .issue_valid(issue_valid), .issue_rs_id(issue_rs_id), .issue_rt_id(issue_rt_id),
        .issue_use_rs(issue_use_rs), .issue_use_rt(issue_use_rt),
        .issue_wr(issue_wr), .issue_dst_id(issue_dst_id), .issue_ready(issue_ready),
        .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data),
        .flush(flush), .busy(busy), .wb_orphan(wb_orphan)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference model: plain arrays of values and outstanding-write counts.
    logic [DW-1:0] m_regs [NR];
    int            m_pend [NR];
    bit            m_orphan;

    function automatic logic [DW-1:0] m_read(input logic [IW-1:0] id);
        if (id == 0) return '0;
        if (BYP && wb_valid && wb_id == id) return wb_data;
        return m_regs[id];
    endfunction

    function automatic bit m_src_blocked(input bit used, input logic [IW-1:0] s);
        if (!used || s == 0 || m_pend[s] == 0) return 1'b0;
        if (BYP && m_pend[s] == 1 && wb_valid && wb_id == s) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_ready();
        if (flush) return 1'b0;
        if (m_src_blocked(issue_use_rs, issue_rs_id)) return 1'b0;
        if (m_src_blocked(issue_use_rt, issue_rt_id)) return 1'b0;
        if (issue_wr && issue_dst_id != 0 && m_pend[issue_dst_id] == MAXC) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_busy();
        for (int r = 0; r < NR; r++) if (m_pend[r] != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            m_regs[r] = '0;
            m_pend[r] = 0;
        end
        m_orphan = 1'b0;
    endtask

    // Apply one clock edge to the model using the inputs presented this cycle.
    task automatic model_edge();
        bit fire;
        int old_wb;
        fire   = issue_valid && m_ready();
        old_wb = m_pend[wb_id];
        if (wb_valid && wb_id != 0) begin
            m_regs[wb_id] = wb_data;
            if (old_wb == 0 && !flush) m_orphan = 1'b1;
        end
        if (flush) begin
            for (int r = 0; r < NR; r++) m_pend[r] = 0;
        end else begin
            if (fire && issue_wr && issue_dst_id != 0) m_pend[issue_dst_id] += 1;
            if (wb_valid && wb_id != 0 && old_wb > 0) m_pend[wb_id] -= 1;
        end
    endtask

    task automatic idle();
        rd_a_id = '0; rd_b_id = '0;
        issue_valid = 1'b0; issue_use_rs = 1'b0; issue_use_rt = 1'b0; issue_wr = 1'b0;
        issue_rs_id = '0; issue_rt_id = '0; issue_dst_id = '0;
        wb_valid = 1'b0; wb_id = '0; wb_data = '0; flush = 1'b0;
    endtask

    // Advance one clock; leaves time at posedge + 1.
    task automatic step();
        @(posedge sys_clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic issue_dst(input logic [IW-1:0] d);
        idle();
        issue_valid = 1'b1; issue_wr = 1'b1; issue_dst_id = d;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        rd_a_id = 5'd3;
        #1;
        n_tests++; if (rd_a_data !== '0) begin n_fail++; $display("FAIL reset_rd: got %h want 0", rd_a_data); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (wb_orphan !== 1'b0) begin n_fail++; $display("FAIL reset_orphan: got %b want 0", wb_orphan); end
        n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", issue_ready); end
        @(negedge sys_clk);
        rst = 1'b0;
        model_reset();
        // Writes to register 0 are dropped and never counted.
        idle();
        wb_valid = 1'b1; wb_id = '0; wb_data = 32'hDEADBEEF;
        #1;
        n_tests++; if (rd_a_data !== '0) begin n_fail++; $display("FAIL x0_rd_same: got %h want 0", rd_a_data); end
        step();
        idle();
        #1;
        n_tests++; if (rd_a_data !== '0) begin n_fail++; $display("FAIL x0_rd: got %h want 0", rd_a_data); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL x0_busy: got %b want 0", busy); end
        n_tests++; if (wb_orphan !== 1'b0) begin n_fail++; $display("FAIL x0_orphan: got %b want 0", wb_orphan); end
        // Reset mid-operation drops pending state immediately.
        issue_dst(5'd4);
        step();
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_pre: got %b want 1", busy); end
        idle();
        rst = 1'b1;
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy_async: got %b want 0", busy); end
        rst = 1'b0;
        model_reset();
        wb_valid = 1'b1; wb_id = 5'd4; wb_data = 32'h1;
        step();
        n_tests++; if (wb_orphan !== 1'b1) begin n_fail++; $display("FAIL midrst_orphan: got %b want 1", wb_orphan); end
    endtask

    task automatic test_raw_stall();
        do_reset();
        issue_dst(5'd5);
        #1;
        n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL raw_issue_ready: got %b want 1", issue_ready); end
        step();
        idle();
        issue_valid = 1'b1; issue_use_rs = 1'b1; issue_rs_id = 5'd5; rd_a_id = 5'd5;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_tests++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall%0d: got %b want 0", c, issue_ready); end
            step();
        end
        wb_valid = 1'b1; wb_id = 5'd5; wb_data = 32'h1234;
        #1;
        n_tests++; if (issue_ready !== BYP) begin n_fail++; $display("FAIL raw_retire_ready: got %b want %b", issue_ready, BYP); end
        n_tests++; if (rd_a_data !== (BYP ? 32'h1234 : 32'h0)) begin n_fail++; $display("FAIL raw_retire_rd: got %h want %h", rd_a_data, BYP ? 32'h1234 : 32'h0); end
        step();
        wb_valid = 1'b0;
        #1;
        n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL raw_after_ready: got %b want 1", issue_ready); end
        n_tests++; if (rd_a_data !== 32'h1234) begin n_fail++; $display("FAIL raw_after_rd: got %h want 1234", rd_a_data); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL raw_busy: got %b want 0", busy); end
        step();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            issue_dst(5'd7);
            #1;
            n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL sat_issue%0d: got %b want 1", k, issue_ready); end
            step();
        end
        #1;
        n_tests++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL sat_full: got %b want 0", issue_ready); end
        step();
        wb_valid = 1'b1; wb_id = 5'd7; wb_data = 32'h77;
        #1;
        n_tests++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL sat_retire_cycle: got %b want 0", issue_ready); end
        step();
        wb_valid = 1'b0;
        #1;
        n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL sat_restored: got %b want 1", issue_ready); end
        issue_valid = 1'b0;
        step();
    endtask

    task automatic test_simultaneous();
        do_reset();
        issue_dst(5'd3);
        step();
        issue_dst(5'd3);
        wb_valid = 1'b1; wb_id = 5'd3; wb_data = 32'hA5A5A5A5;
        #1;
        n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL sim_ready: got %b want 1", issue_ready); end
        step();
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL sim_busy: got %b want 1", busy); end
        idle();
        rd_a_id = 5'd3;
        #1;
        n_tests++; if (rd_a_data !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL sim_data: got %h want a5a5a5a5", rd_a_data); end
        // A single further retire drains the counter exactly.
        wb_valid = 1'b1; wb_id = 5'd3; wb_data = 32'h1;
        step();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sim_drain_busy: got %b want 0", busy); end
        n_tests++; if (wb_orphan !== 1'b0) begin n_fail++; $display("FAIL sim_drain_orphan: got %b want 0", wb_orphan); end
    endtask

    task automatic test_flush();
        do_reset();
        issue_dst(5'd9);
        step();
        issue_dst(5'd10);
        step();
        issue_dst(5'd11);
        flush = 1'b1;
        wb_valid = 1'b1; wb_id = 5'd9; wb_data = 32'h55;
        #1;
        n_tests++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", issue_ready); end
        step();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b want 0", busy); end
        n_tests++; if (wb_orphan !== 1'b0) begin n_fail++; $display("FAIL flush_orphan: got %b want 0", wb_orphan); end
        idle();
        rd_a_id = 5'd9;
        #1;
        n_tests++; if (rd_a_data !== 32'h55) begin n_fail++; $display("FAIL flush_data: got %h want 55", rd_a_data); end
        // r10 was cleared, so its retire is now an orphan.
        wb_valid = 1'b1; wb_id = 5'd10; wb_data = 32'h10;
        step();
        n_tests++; if (wb_orphan !== 1'b1) begin n_fail++; $display("FAIL flush_cleared: got %b want 1", wb_orphan); end
    endtask

    task automatic test_orphan();
        do_reset();
        wb_valid = 1'b1; wb_id = 5'd12; wb_data = 32'hC;
        step();
        n_tests++; if (wb_orphan !== 1'b1) begin n_fail++; $display("FAIL orphan_set: got %b want 1", wb_orphan); end
        idle();
        for (int c = 0; c < 3; c++) step();
        n_tests++; if (wb_orphan !== 1'b1) begin n_fail++; $display("FAIL orphan_sticky: got %b want 1", wb_orphan); end
        do_reset();
        #1;
        n_tests++; if (wb_orphan !== 1'b0) begin n_fail++; $display("FAIL orphan_rst: got %b want 0", wb_orphan); end
    endtask

    function automatic logic [IW-1:0] rand_id();
        if ($urandom_range(0, 9) == 0) return IW'($urandom_range(0, NR - 1));
        return IW'($urandom_range(0, 7));
    endfunction

    task automatic test_random();
        int pend_list [$];
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            idle();
            rd_a_id      = rand_id();
            rd_b_id      = rand_id();
            issue_valid  = ($urandom_range(0, 9) < 6);
            issue_use_rs = $urandom_range(0, 1) == 1;
            issue_use_rt = $urandom_range(0, 1) == 1;
            issue_wr     = ($urandom_range(0, 9) < 7);
            issue_rs_id  = rand_id();
            issue_rt_id  = rand_id();
            issue_dst_id = rand_id();
            wb_valid     = ($urandom_range(0, 9) < 4);
            wb_data      = $urandom;
            flush        = ($urandom_range(0, 39) == 0);
            pend_list.delete();
            for (int r = 1; r < NR; r++) if (m_pend[r] != 0) pend_list.push_back(r);
            if (pend_list.size() != 0 && $urandom_range(0, 9) < 8)
                wb_id = IW'(pend_list[$urandom_range(0, pend_list.size() - 1)]);
            else
                wb_id = rand_id();
            #1;
            n_tests++; if (rd_a_data !== m_read(rd_a_id)) begin n_fail++; $display("FAIL rnd_rd_a c%0d: got %h want %h", cyc, rd_a_data, m_read(rd_a_id)); end
            n_tests++; if (rd_b_data !== m_read(rd_b_id)) begin n_fail++; $display("FAIL rnd_rd_b c%0d: got %h want %h", cyc, rd_b_data, m_read(rd_b_id)); end
            n_tests++; if (issue_ready !== m_ready()) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, issue_ready, m_ready()); end
            step();
            n_tests++; if (busy !== m_busy()) begin n_fail++; $display("FAIL rnd_busy c%0d: got %b want %b", cyc, busy, m_busy()); end
            n_tests++; if (wb_orphan !== m_orphan) begin n_fail++; $display("FAIL rnd_orphan c%0d: got %b want %b", cyc, wb_orphan, m_orphan); end
        end
    endtask

    initial begin
        test_reset();
        test_raw_stall();
        test_saturation();
        test_simultaneous();
        test_flush();
        test_orphan();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
